// File: rtl/memaccess.sv
// Memory-access pipeline stage: non-memory ops pass straight through in one cycle,
// loads/stores hold the stage in ACCESS until dmem_ack or a wait-count timeout.
module memaccess #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [3:0]  rd_num_in,
    input  logic [31:0] result_in,
    input  logic [31:0] cpsr_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] st_data_in,
    input  logic        is_alu_op_in,
    input  logic        is_cmp_op_in,
    input  logic        is_ld_op_in,
    input  logic        is_st_op_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [3:0]  rd_num_passthrough,
    output logic [31:0] mem_passthrough,
    output logic [31:0] result,
    output logic [31:0] cpsr_passthrough,
    output logic [31:0] dmem_val_passthrough,
    output logic        is_alu_op_passthrough,
    output logic        is_cmp_op_passthrough,
    output logic        is_ld_op_passthrough,
    output logic        bus_err
);

    typedef enum logic {IDLE, ACCESS} state_e;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  rd_b_q, rd_b_d;
    logic [31:0] res_b_q, res_b_d, cpsr_b_q, cpsr_b_d;
    logic [3:0]  rd_q, rd_d;
    logic [31:0] mem_q, mem_d, res_q, res_d, cpsr_q, cpsr_d, dval_q, dval_d;
    logic        alu_q, alu_d, cmp_q, cmp_d, ld_q, ld_d, berr_q, berr_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_b_d   = rd_b_q;
        res_b_d  = res_b_q;
        cpsr_b_d = cpsr_b_q;
        rd_d     = rd_q;
        mem_d    = mem_q;
        res_d    = res_q;
        cpsr_d   = cpsr_q;
        dval_d   = dval_q;
        // Op flags and bus_err are single-cycle strobes.
        alu_d    = 1'b0;
        cmp_d    = 1'b0;
        ld_d     = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_ld_op_in || is_st_op_in) begin
                        state_d  = ACCESS;
                        cnt_d    = 8'd0;
                        req_d    = 1'b1;
                        we_d     = is_st_op_in & ~is_ld_op_in;
                        addr_d   = mem_addr_in;
                        wdata_d  = st_data_in;
                        rd_b_d   = rd_num_in;
                        res_b_d  = result_in;
                        cpsr_b_d = cpsr_in;
                    end else begin
                        rd_d   = rd_num_in;
                        res_d  = result_in;
                        cpsr_d = cpsr_in;
                        mem_d  = mem_addr_in;
                        alu_d  = is_alu_op_in;
                        cmp_d  = is_cmp_op_in;
                    end
                end
            end
            ACCESS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rd_d    = rd_b_q;
                    res_d   = res_b_q;
                    cpsr_d  = cpsr_b_q;
                    mem_d   = addr_q;
                    if (!we_q) begin
                        dval_d = dmem_rdata;
                        ld_d   = 1'b1;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_b_q   <= '0;
            res_b_q  <= '0;
            cpsr_b_q <= '0;
            rd_q     <= '0;
            mem_q    <= '0;
            res_q    <= '0;
            cpsr_q   <= '0;
            dval_q   <= '0;
            alu_q    <= 1'b0;
            cmp_q    <= 1'b0;
            ld_q     <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_b_q   <= rd_b_d;
            res_b_q  <= res_b_d;
            cpsr_b_q <= cpsr_b_d;
            rd_q     <= rd_d;
            mem_q    <= mem_d;
            res_q    <= res_d;
            cpsr_q   <= cpsr_d;
            dval_q   <= dval_d;
            alu_q    <= alu_d;
            cmp_q    <= cmp_d;
            ld_q     <= ld_d;
            berr_q   <= berr_d;
        end
    end

    assign ready_out             = (state_q == IDLE);
    assign dmem_req              = req_q;
    assign dmem_we               = we_q;
    assign dmem_addr             = addr_q;
    assign dmem_wdata            = wdata_q;
    assign rd_num_passthrough    = rd_q;
    assign mem_passthrough       = mem_q;
    assign result                = res_q;
    assign cpsr_passthrough      = cpsr_q;
    assign dmem_val_passthrough  = dval_q;
    assign is_alu_op_passthrough = alu_q;
    assign is_cmp_op_passthrough = cmp_q;
    assign is_ld_op_passthrough  = ld_q;
    assign bus_err               = berr_q;

endmodule

// File: doc/memaccess.md
MEMACCESS -- requirements
Module: memaccess

Interface
REQ-001 Parameter TIMEOUT, default 16, the number of cycles to wait for dmem_ack before a bus-error abort (legal range 1..255).
REQ-002 clk  in  1  single rising-edge clock for the whole block.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  execute stage presents an instruction this cycle.
REQ-005 ready_out  out  1  the stage can accept; a transfer occurs when valid_in and ready_out are both 1 at a rising edge.
REQ-006 rd_num_in  in  4 / result_in  in  32 / cpsr_in  in  32  are the execute results: destination register, ALU result, NZCV word.
REQ-007 mem_addr_in  in  32 / st_data_in  in  32  are the data-memory address and the store data.
REQ-008 is_alu_op_in, is_cmp_op_in, is_ld_op_in, is_st_op_in  in  1 each  are the operation class.
REQ-009 dmem_req  out  1 / dmem_we  out  1 / dmem_addr  out  32 / dmem_wdata  out  32  form the data-memory request.
REQ-010 dmem_ack  in  1 / dmem_rdata  in  32  are the memory completion signal and the load data.
REQ-011 rd_num_passthrough  out  4 / mem_passthrough  out  32 / result  out  32 / cpsr_passthrough  out  32 / dmem_val_passthrough  out  32  feed writeback.
REQ-012 is_alu_op_passthrough, is_cmp_op_passthrough, is_ld_op_passthrough  out  1 each  are the writeback op flags.
REQ-013 bus_err  out  1  is a one-cycle pulse indicating an aborted memory access.

Function
REQ-014 The FSM SHALL have two states, IDLE and ACCESS; ready_out SHALL equal (state==IDLE) combinationally.
REQ-015 An accepted non-memory op (is_ld_op_in=0 and is_st_op_in=0) SHALL register all passthrough data and its flags at that edge, giving 1-cycle latency; the FSM SHALL stay in IDLE.
REQ-016 An accepted ld or st SHALL move the FSM to ACCESS and, at the same edge, register dmem_req=1, dmem_addr=mem_addr_in, dmem_wdata=st_data_in, and dmem_we=is_st_op_in&~is_ld_op_in.
REQ-017 If is_ld_op_in and is_st_op_in are both 1, the op SHALL be treated as a load.
REQ-018 In ACCESS, the dmem_* outputs SHALL remain stable until completion or abort.
REQ-019 dmem_ack SHALL be sampled only in ACCESS; an ack seen in IDLE SHALL be ignored.
REQ-020 On an ack edge in ACCESS, the FSM SHALL return to IDLE and drop dmem_req.
REQ-021 On a load completion, the outputs SHALL be registered with dmem_val_passthrough=dmem_rdata, is_ld_op_passthrough=1, and the buffered rd_num, result, cpsr and addr (addr on mem_passthrough).
REQ-022 On a store completion, the passthrough data SHALL be registered with all op flags 0, so no writeback occurs.
REQ-023 An 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without ack.
REQ-024 When the wait counter reaches TIMEOUT-1 with no ack, the block SHALL abort: return to IDLE, drop dmem_req, clear all flags, and pulse bus_err for exactly 1 cycle.
REQ-025 An ack arriving in the same cycle as the timeout SHALL take priority over the timeout (normal completion, no bus_err).
REQ-026 Output op flags SHALL be 1 for exactly one cycle per completed instruction and SHALL clear on any edge with no accept or completion; data outputs SHALL hold their last value.
REQ-027 valid_in SHALL be ignored while in ACCESS; the upstream stage holds its inputs until ready_out=1.

Reset
REQ-028 While reset=0, the block SHALL asynchronously enter IDLE, clear the counter, and drive all outputs to 0 except ready_out=1.
REQ-029 A reset asserted mid-ACCESS SHALL abandon the access with no bus_err and no flags.

Verification
REQ-030 ALU op: rd_num_in=5, result_in=0x1234, is_alu_op_in=1 -> next cycle rd_num_passthrough=5, result=0x1234, is_alu_op_passthrough=1 for 1 cycle.
REQ-031 CMP op: cpsr_in=0x8 -> next cycle cpsr_passthrough=0x8, is_cmp_op_passthrough=1; ready_out stays 1.
REQ-032 Load: addr=0x40, rd=3, ack after 3 cycles with rdata=0xDEADBEEF -> ready_out=0 for 3 cycles, then dmem_val_passthrough=0xDEADBEEF, is_ld_op_passthrough=1, rd_num_passthrough=3.
REQ-033 Store: addr=0x44, st_data=0xA5 -> dmem_we=1, dmem_wdata=0xA5 until ack; after ack all flags 0.
REQ-034 Timeout: TIMEOUT=4, load with no ack -> abort after 4 ACCESS cycles, bus_err=1 for 1 cycle, flags 0, ready_out=1; repeat with ack on the 4th cycle -> completes with no bus_err.
REQ-035 Reset mid-ACCESS: drive reset=0 during a load -> dmem_req=0, ready_out=1 immediately; a stray ack afterwards produces no output.
